writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Parametrised successor to the single-record writeback stage.
- Buffers up to DEPTH completed memory-stage records in a FIFO and retires one per cycle in program order to the register file and the commit/difftest interface.
- Adds a valid/ready handshake with memory, back-pressure from the commit side, and flush.
- Provides multi-port youngest-first forwarding from buffered records to decode.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- XLEN, 64, width of result and pc.
- RADDR_W, 5, register address width.
- NFWD, 2, number of forwarding lookup ports.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  memory stage presents a record
- in_ready  out  1  queue can accept (not full)
- in_regwrite  in  1  record writes a register
- in_memaccess  in  1  record is a load or store
- in_addr_31  in  1  bit 31 of the memory address
- in_nop  in  1  bubble record; occupies a slot but is not counted as a retired instruction
- in_wa  in  RADDR_W  destination register
- in_wd  in  XLEN  memory/load data
- in_alu  in  XLEN  ALU result
- in_pc  in  XLEN  instruction pc
- out_ready  in  1  commit side accepts a retirement this cycle
- regwrite  out  1  register-file write enable (head retires with regwrite and wa != 0)
- wa  out  RADDR_W  head destination register
- result  out  XLEN  head result
- pc_result  out  XLEN  head pc
- pc_valid  out  1  head retires and is not a nop
- skip  out  1  head retires, is a memory access, and addr_31 == 0
- flush  in  1  discard all buffered records
- fwd_ra  in  NFWD*RADDR_W  lookup addresses, port i at bits [i*RADDR_W +: RADDR_W]
- fwd_hit  out  NFWD  hit per lookup port
- fwd_data  out  NFWD*XLEN  forwarded value per lookup port
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, active-high): head = tail = 0, count = 0, all entry valid bits cleared.
  - While reset is asserted: in_ready = 0, regwrite = 0, pc_valid = 0, skip = 0, wa = 0, result = 0, pc_result = 0, fwd_hit = 0.
  - Reset mid-transfer drops every record; no partial retirement occurs.
- Enqueue: occurs when in_valid && in_ready at a clk edge. Result selection happens at enqueue:
  - stored result = in_wd if in_memaccess, otherwise in_alu;
  - stored skip = in_memaccess && !in_addr_31.
- in_ready = (count < DEPTH) && !flush.
  - Combinational from registered count only; it must not depend on out_ready.
  - A full queue refuses input even when a retirement happens in the same cycle.
- Retire: occurs when count != 0 && out_ready. All retire outputs are combinational from the head entry and are qualified by retirement; they read 0 when not retiring. The head pointer advances on the edge.
- Latency: a record enqueued at edge N is at the head from cycle N+1. With an empty queue and out_ready = 1 it retires in cycle N+1.
- Throughput: one enqueue and one retirement per cycle. Simultaneous enqueue and retirement leave count unchanged.
- Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. Full and empty are decided from count, never from pointer equality.
- Flush: takes priority over enqueue and retirement in the same cycle.
  - Outputs are gated to 0 during the flush cycle.
  - Next cycle: count = 0, head = tail, all valid bits cleared.
- Forwarding (combinational) for each port i:
  - Search valid entries from youngest (tail-1) to oldest (head) for regwrite && wa == fwd_ra[i].
  - First match: fwd_hit[i] = 1, fwd_data[i] = that entry's result.
  - fwd_ra[i] == 0 never hits.
  - The head entry is searchable in its retirement cycle.
  - The incoming (not yet enqueued) record is not searched.
- Nop records: regwrite is forced to 0 at enqueue, so they never hit in forwarding.

Decomposition:
- Shared package pipes: typedef wbq_entry_t {valid, regwrite, skip, nop, wa, result, pc}, and constant WBQ_DEPTH_DEFAULT.
- Shared package common: existing word_t, u64, creg_addr_t.
- One sub-module: wbq_fwd_lookup, the youngest-first priority search for a single port, instantiated NFWD times via generate.

Test Plan:
- Single ALU record (wa=5, alu=0x1234, pc=0x80000000), out_ready=1 -> cycle after enqueue: regwrite=1, wa=5, result=0x1234, pc_valid=1, skip=0.
- Load with addr_31=0 (wd=0xdead, alu=0x40) -> retires with result=0xdead and skip=1; a store with addr_31=1 -> skip=0.
- out_ready=0 while 5 records are offered at DEPTH=4 -> in_ready drops after the 4th, count=4, the 5th is held by the producer; raising out_ready retires all in order and takes the 5th without loss.
- Two buffered writes to x7 (0x1 older, 0x2 younger) with fwd_ra port0=7, port1=0 -> fwd_hit=2'b01, port0 data=0x2.
- Flush with 3 entries while in_valid=1 and out_ready=1 -> no retirement and no enqueue that cycle; count=0 next cycle; fwd_hit=0.
- Reset asserted asynchronously mid-stream with 2 entries -> outputs immediately 0; after release count=0 and the first new record retires normally.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared types for the writeback queue: machine word types, the buffered
// record layout and the result-select helper applied at enqueue.
package writeback_queue_pkg;

    localparam int WBQ_DEPTH_DEFAULT = 4;

    typedef logic [63:0] u64;
    typedef u64          word_t;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       skip;
        logic       nop;
        creg_addr_t wa;
        word_t      result;
        word_t      pc;
    } wbq_entry_t;

    function automatic word_t wbq_select_result(input logic memaccess, input word_t wd, input word_t alu);
        return memaccess ? wd : alu;
    endfunction

endpackage

// File: rtl/writeback_queue_fwd_lookup.sv
// Single forwarding port: scans occupied entries from youngest (tail-1) to
// oldest and returns the result of the first register-writing match.
module wbq_fwd_lookup #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic [$clog2(DEPTH)-1:0] tail,
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0]         regwrite,
    input  logic [DEPTH*RADDR_W-1:0] wa,
    input  logic [DEPTH*XLEN-1:0]    result,
    input  logic [RADDR_W-1:0]       ra,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx_s;
    logic          match_s;

    // Youngest-first priority search; the first hit latches and blocks older matches.
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        idx_s   = '0;
        match_s = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx_s   = tail - PW'(k);
            match_s = valid[idx_s] && regwrite[idx_s] && (ra != '0)
                      && (wa[idx_s*RADDR_W +: RADDR_W] == ra);
            data    = (match_s && !hit) ? result[idx_s*XLEN +: XLEN] : data;
            hit     = hit | match_s;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers completed memory-stage records, retires one per
// cycle in program order and forwards buffered results youngest-first.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH   = WBQ_DEPTH_DEFAULT,
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int NFWD    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_regwrite,
    input  logic                      in_memaccess,
    input  logic                      in_addr_31,
    input  logic                      in_nop,
    input  logic [RADDR_W-1:0]        in_wa,
    input  logic [XLEN-1:0]           in_wd,
    input  logic [XLEN-1:0]           in_alu,
    input  logic [XLEN-1:0]           in_pc,
    input  logic                      out_ready,
    output logic                      regwrite,
    output logic [RADDR_W-1:0]        wa,
    output logic [XLEN-1:0]           result,
    output logic [XLEN-1:0]           pc_result,
    output logic                      pc_valid,
    output logic                      skip,
    input  logic                      flush,
    input  logic [NFWD*RADDR_W-1:0]   fwd_ra,
    output logic [NFWD-1:0]           fwd_hit,
    output logic [NFWD*XLEN-1:0]      fwd_data,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wbq_entry_t       mem_q [DEPTH];
    wbq_entry_t       mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             enq_s, retire_s, gate_s;
    wbq_entry_t       new_s, head_s;

    logic [DEPTH-1:0]         valid_vec_s, rw_vec_s;
    logic [DEPTH*RADDR_W-1:0] wa_vec_s;
    logic [DEPTH*XLEN-1:0]    res_vec_s;

    // Full is judged from registered occupancy only, so a same-cycle retirement never opens a slot.
    assign gate_s   = reset || flush;
    assign in_ready = !gate_s && (count_q < FULL_CNT);
    assign enq_s    = in_valid && in_ready;
    assign head_s   = mem_q[head_q];
    assign retire_s = !gate_s && out_ready && (count_q != '0) && head_s.valid;
    assign count    = count_q;

    // Build the record to store; result and skip are resolved here, nops never write.
    always_comb begin
        new_s          = '0;
        new_s.valid    = 1'b1;
        new_s.regwrite = in_regwrite && !in_nop;
        new_s.skip     = in_memaccess && !in_addr_31;
        new_s.nop      = in_nop;
        new_s.wa       = creg_addr_t'(in_wa);
        new_s.result   = wbq_select_result(in_memaccess, word_t'(in_wd), word_t'(in_alu));
        new_s.pc       = word_t'(in_pc);
    end

    // Retirement outputs, driven from the head entry only while it retires.
    always_comb begin
        regwrite  = 1'b0;
        wa        = '0;
        result    = '0;
        pc_result = '0;
        pc_valid  = 1'b0;
        skip      = 1'b0;
        if (retire_s) begin
            regwrite  = head_s.regwrite && (head_s.wa != '0);
            wa        = head_s.wa[RADDR_W-1:0];
            result    = head_s.result[XLEN-1:0];
            pc_result = head_s.pc[XLEN-1:0];
            pc_valid  = !head_s.nop;
            skip      = head_s.skip;
        end else begin
            regwrite  = 1'b0;
            pc_valid  = 1'b0;
        end
    end

    // Next-state for storage, pointers and occupancy; flush overrides both enqueue and retire.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].valid = 1'b0;
            end
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (enq_s) begin
                mem_d[tail_q] = new_s;
                tail_d        = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (retire_s) begin
                mem_d[head_q].valid = 1'b0;
                head_d              = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            if (enq_s && !retire_s) begin
                count_d = count_q + CW'(1);
            end else if (!enq_s && retire_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers; reset drops every buffered record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Flatten entry fields for the lookup ports.
    always_comb begin
        valid_vec_s = '0;
        rw_vec_s    = '0;
        wa_vec_s    = '0;
        res_vec_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec_s[i]                  = mem_q[i].valid;
            rw_vec_s[i]                     = mem_q[i].regwrite;
            wa_vec_s[i*RADDR_W +: RADDR_W]  = mem_q[i].wa[RADDR_W-1:0];
            res_vec_s[i*XLEN +: XLEN]       = mem_q[i].result[XLEN-1:0];
        end
    end

    for (genvar p = 0; p < NFWD; p++) begin : g_fwd
        logic            hit_s;
        logic [XLEN-1:0] data_s;

        wbq_fwd_lookup #(
            .DEPTH   (DEPTH),
            .XLEN    (XLEN),
            .RADDR_W (RADDR_W)
        ) u_lookup (
            .tail     (tail_q),
            .valid    (valid_vec_s),
            .regwrite (rw_vec_s),
            .wa       (wa_vec_s),
            .result   (res_vec_s),
            .ra       (fwd_ra[p*RADDR_W +: RADDR_W]),
            .hit      (hit_s),
            .data     (data_s)
        );

        assign fwd_hit[p]                = hit_s && !gate_s;
        assign fwd_data[p*XLEN +: XLEN]  = (hit_s && !gate_s) ? data_s : '0;
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: records are queued as expected
// entries on acceptance and compared field-by-field when they retire.
module tb_writeback_queue;
    localparam int DEPTH   = 4;
    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;
    localparam int NFWD    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready, in_regwrite, in_memaccess, in_addr_31, in_nop;
    logic [RADDR_W-1:0]      in_wa;
    logic [XLEN-1:0]         in_wd, in_alu, in_pc;
    logic                    out_ready, regwrite, pc_valid, skip, flush;
    logic [RADDR_W-1:0]      wa;
    logic [XLEN-1:0]         result, pc_result;
    logic [NFWD*RADDR_W-1:0] fwd_ra;
    logic [NFWD-1:0]         fwd_hit;
    logic [NFWD*XLEN-1:0]    fwd_data;
    logic [$clog2(DEPTH):0]  count;

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RADDR_W(RADDR_W), .NFWD(NFWD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memaccess(in_memaccess), .in_addr_31(in_addr_31),
        .in_nop(in_nop), .in_wa(in_wa), .in_wd(in_wd), .in_alu(in_alu), .in_pc(in_pc),
        .out_ready(out_ready), .regwrite(regwrite), .wa(wa), .result(result),
        .pc_result(pc_result), .pc_valid(pc_valid), .skip(skip), .flush(flush),
        .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwrite, memaccess, addr31, nop;
        logic [4:0]  wa;
        logic [63:0] wd, alu, pc;
    } stim_t;

    typedef struct {
        logic        rw, nop, skip;
        logic [4:0]  wa;
        logic [63:0] res, pc;
    } ent_t;

    stim_t pend[$];
    ent_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t to_ent(input stim_t s);
        ent_t e;
        e.rw   = s.regwrite && !s.nop;
        e.nop  = s.nop;
        e.skip = s.memaccess && !s.addr31;
        e.wa   = s.wa;
        e.res  = s.memaccess ? s.wd : s.alu;
        e.pc   = s.pc;
        return e;
    endfunction

    task automatic push_rec(input logic rw, input logic mem, input logic a31, input logic nop,
                            input logic [4:0] w, input logic [63:0] wd, input logic [63:0] alu,
                            input logic [63:0] pc);
        stim_t s;
        s.regwrite = rw; s.memaccess = mem; s.addr31 = a31; s.nop = nop;
        s.wa = w; s.wd = wd; s.alu = alu; s.pc = pc;
        pend.push_back(s);
    endtask

    // One clock: drive from the producer queue, check at negedge, update model at posedge.
    task automatic cycle();
        logic exp_rdy, do_enq, do_ret;
        ent_t h;
        if (pend.size() > 0) begin
            in_valid = 1'b1; in_regwrite = pend[0].regwrite; in_memaccess = pend[0].memaccess;
            in_addr_31 = pend[0].addr31; in_nop = pend[0].nop; in_wa = pend[0].wa;
            in_wd = pend[0].wd; in_alu = pend[0].alu; in_pc = pend[0].pc;
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        exp_rdy = (sb.size() < DEPTH) && !flush;
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("count", count, sb.size());
        do_ret = !flush && out_ready && (sb.size() > 0);
        if (do_ret) begin
            h = sb[0];
            check_eq("ret_regwrite", regwrite, h.rw && (h.wa != 5'd0));
            check_eq("ret_wa", wa, h.wa);
            check_eq("ret_result", result, h.res);
            check_eq("ret_pc", pc_result, h.pc);
            check_eq("ret_pc_valid", pc_valid, !h.nop);
            check_eq("ret_skip", skip, h.skip);
        end else begin
            check_eq("idle_ctl", {regwrite, pc_valid, skip}, 3'b000);
            check_eq("idle_wa", wa, 5'd0);
            check_eq("idle_result", result, 64'd0);
            check_eq("idle_pc", pc_result, 64'd0);
        end
        for (int p = 0; p < NFWD; p++) begin
            logic [4:0]  ra;
            logic        eh;
            logic [63:0] ed;
            ra = fwd_ra[p*RADDR_W +: RADDR_W];
            eh = 1'b0;
            ed = 64'd0;
            if (!flush && ra != 5'd0) begin
                for (int j = sb.size() - 1; j >= 0; j--) begin
                    if (!eh && sb[j].rw && sb[j].wa == ra) begin
                        eh = 1'b1;
                        ed = sb[j].res;
                    end
                end
            end
            check_eq($sformatf("fwd_hit%0d", p), fwd_hit[p], eh);
            check_eq($sformatf("fwd_data%0d", p), fwd_data[p*XLEN +: XLEN], ed);
        end
        do_enq = in_valid && exp_rdy;
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_ret) void'(sb.pop_front());
            if (do_enq) sb.push_back(to_ent(pend.pop_front()));
        end
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check_eq("drain_left", pend.size() + sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_memaccess = 1'b0;
        in_addr_31 = 1'b0; in_nop = 1'b0; in_wa = '0; in_wd = '0; in_alu = '0; in_pc = '0;
        out_ready = 1'b1; flush = 1'b0; fwd_ra = '0;
        #2;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_count", count, 0);
        check_eq("rst_ctl", {regwrite, pc_valid, skip}, 3'b000);
        @(posedge clk); #1 reset = 1'b0;

        // Single ALU record.
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 64'h0, 64'h1234, 64'h8000_0000);
        drain(10);

        // Load with addr_31 = 0 then store with addr_31 = 1.
        push_rec(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 64'hdead, 64'h40, 64'h8000_0004);
        push_rec(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 64'hbeef, 64'h44, 64'h8000_0008);
        drain(10);

        // Back-pressure: five offered into four slots.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'(i + 1), 64'h0, 64'h100 + 64'(i), 64'h1000 + 64'(4 * i));
        repeat (6) cycle();
        out_ready = 1'b1;
        drain(20);

        // Youngest-first forwarding on x7; port1 looks up x0.
        out_ready = 1'b0;
        fwd_ra = {5'd0, 5'd7};
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 64'h0, 64'h1, 64'h2000);
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 64'h0, 64'h2, 64'h2004);
        repeat (3) cycle();
        out_ready = 1'b1;
        drain(10);

        // Flush with three entries while input is offered and commit is ready.
        out_ready = 1'b0;
        fwd_ra = {5'd9, 5'd8};
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 64'h0, 64'h88, 64'h3000);
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 64'h0, 64'h99, 64'h3004);
        push_rec(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 64'h0, 64'haa, 64'h3008);
        repeat (3) cycle();
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 64'h0, 64'hbb, 64'h300c);
        out_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drain(10);

        // Mixed random traffic with nops, stalls and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            if (pend.size() < 2 && $urandom_range(0, 3) != 0)
                push_rec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 7)),
                         {$urandom, $urandom}, {$urandom, $urandom}, 64'(c * 4));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            fwd_ra    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // Asynchronous reset with two buffered entries while the head would retire.
        out_ready = 1'b0;
        fwd_ra = {5'd11, 5'd10};
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 64'h0, 64'hab, 64'h4000);
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 64'h0, 64'hcd, 64'h4004);
        repeat (2) cycle();
        out_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        check_eq("arst_ctl", {regwrite, pc_valid, skip}, 3'b000);
        check_eq("arst_wa", wa, 5'd0);
        check_eq("arst_result", result, 64'd0);
        check_eq("arst_pc", pc_result, 64'd0);
        check_eq("arst_fwd_hit", fwd_hit, 2'b00);
        check_eq("arst_in_ready", in_ready, 1'b0);
        check_eq("arst_count", count, 0);
        sb.delete();
        pend.delete();
        in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        push_rec(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 64'h0, 64'h5678, 64'h5000);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
